// File: rtl/spi_master_mode0_if.sv
// spi_master_mode0_if: request/response handshake and SPI pins of the Mode 0 engine
interface spi_master_mode0_if;
    logic       sensor_select;
    logic       write_start;
    logic [7:0] write_data;
    logic [2:0] write_count_bytes;
    logic       write_ready;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       cs_gyro_n;
    logic       cs_accl_n;
    logic [7:0] read_data;
    logic       read_valid;
    logic [2:0] read_index;
    modport master (
        output sensor_select, write_start, write_data, write_count_bytes, miso,
        input  write_ready, sclk, mosi, cs_gyro_n, cs_accl_n, read_data, read_valid, read_index
    );
    modport slave (
        input  sensor_select, write_start, write_data, write_count_bytes, miso,
        output write_ready, sclk, mosi, cs_gyro_n, cs_accl_n, read_data, read_valid, read_index
    );
endinterface

// File: rtl/spi_master_mode0.sv
// spi_master_mode0: SPI Mode 0 engine sending an address byte then reading N-1 sensor bytes
module spi_master_mode0 #(
    parameter int CLK_DIV = 4
) (
    input logic clk,
    input logic reset,
    spi_master_mode0_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT_HI, SHIFT_LO, CS_GAP} state_t;
    state_t state, state_nx;
    logic [7:0] div_cnt;
    logic [5:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] nbytes;
    logic sel;
    logic armed;
    logic in_frame;
    logic phase_end;
    logic accept;
    logic sample;

    assign phase_end = div_cnt == 8'(CLK_DIV - 1);
    assign accept    = bus.write_start && bus.write_ready;
    assign sample    = state == SHIFT_HI && div_cnt == 8'd0;

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // next-state: every non-idle phase lasts CLK_DIV clocks; the low phase after the last bit doubles as CS hold
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = CS_SETUP;
            CS_SETUP: if (phase_end) state_nx = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_nx = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_nx = (bit_cnt == {nbytes, 3'b000}) ? CS_GAP : SHIFT_HI;
            CS_GAP:   if (phase_end) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // pin outputs decoded from state so reset forces them idle asynchronously
    always_comb begin
        in_frame        = state inside {CS_SETUP, SHIFT_HI, SHIFT_LO};
        bus.write_ready = armed && state == IDLE;
        bus.sclk        = state == SHIFT_HI;
        bus.mosi        = in_frame && tx_sr[7];
        bus.cs_gyro_n   = !(in_frame && !sel);
        bus.cs_accl_n   = !(in_frame && sel);
    end

    // datapath: phase timer, request latch, shift registers and the received-byte strobe
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            armed          <= 1'b0;
            div_cnt        <= 8'd0;
            bit_cnt        <= 6'd0;
            tx_sr          <= 8'd0;
            rx_sr          <= 8'd0;
            nbytes         <= 3'd1;
            sel            <= 1'b0;
            bus.read_data  <= 8'd0;
            bus.read_valid <= 1'b0;
            bus.read_index <= 3'd0;
        end else begin
            armed          <= 1'b1;
            div_cnt        <= (state != state_nx || state == IDLE) ? 8'd0 : div_cnt + 8'd1;
            bus.read_valid <= 1'b0;
            if (accept) begin
                sel     <= bus.sensor_select;
                tx_sr   <= bus.write_data;
                nbytes  <= (bus.write_count_bytes == 3'd0) ? 3'd1 : bus.write_count_bytes;
                bit_cnt <= 6'd0;
            end
            if (state == SHIFT_HI && phase_end) tx_sr <= {tx_sr[6:0], 1'b0};
            if (sample) begin
                rx_sr   <= {rx_sr[6:0], bus.miso};
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt[2:0] == 3'd7 && bit_cnt[5:3] != 3'd0) begin
                    bus.read_data  <= {rx_sr[6:0], bus.miso};
                    bus.read_index <= bit_cnt[5:3];
                    bus.read_valid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_spi_master_mode0.sv
// tb_spi_master_mode0: table-driven and randomized checks of spi_master_mode0 against a transaction-level model
module tb_spi_master_mode0;
    localparam int CLK_DIV = 4;

    typedef struct {
        bit         sel;
        logic [7:0] data;
        logic [2:0] cnt;
        logic [63:0] mb;
        int         exp_busy;
        int         exp_edges;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    spi_master_mode0_if bus();

    spi_master_mode0 #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int g_low = 0, a_low = 0, both_low = 0, rv_wide = 0, phase_err = 0;
    int run = 0, hi_run = 0, last_gap = 0;
    bit prev_rv = 0, prev_cs = 0, prev_sclk = 0;
    int falls = 0, base = 0, pos;
    logic [63:0] miso_flat = '0;
    bit mosi_q[$];
    int rv_q[$];
    int g0, a0, e0, r0, m_busy;

    wire cs_any = !(bus.cs_gyro_n && bus.cs_accl_n);

    // sensor model: first bit ready at CS assertion, next bit after each SCLK falling edge
    always @(negedge bus.sclk) falls++;
    always @(posedge cs_any) base = falls;
    assign pos = falls - base;
    assign bus.miso = (cs_any && pos >= 0 && pos < 64) ? miso_flat[63 - pos] : 1'b0;

    // cycle counter for busy-time measurement
    always @(posedge clk) cyc++;

    // MOSI capture at each SCLK rising edge inside a frame
    always @(posedge bus.sclk) if (cs_any) mosi_q.push_back(bus.mosi);

    // bus monitor sampled mid-cycle: CS occupancy, read strobes, SCLK phase lengths, CS gap
    always @(negedge clk) begin
        if (!bus.cs_gyro_n) g_low++;
        if (!bus.cs_accl_n) a_low++;
        if (!bus.cs_gyro_n && !bus.cs_accl_n) both_low++;
        if (bus.read_valid) rv_q.push_back(int'({bus.read_index, bus.read_data}));
        if (bus.read_valid && prev_rv) rv_wide++;
        prev_rv = bus.read_valid;
        if (cs_any) begin
            if (!prev_cs) begin
                last_gap = hi_run;
                run = 1;
            end else if (bus.sclk == prev_sclk) run++;
            else begin
                if (run != CLK_DIV) phase_err++;
                run = 1;
            end
            hi_run = 0;
        end else hi_run++;
        prev_cs = cs_any;
        prev_sclk = bus.sclk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.write_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_txn(input bit sel, input logic [7:0] data, input logic [2:0] cnt,
                          input logic [63:0] mb, input int hold);
        int c0;
        wait_ready();
        g0 = g_low; a0 = a_low; e0 = mosi_q.size(); r0 = rv_q.size();
        miso_flat = mb;
        bus.sensor_select = sel;
        bus.write_data = data;
        bus.write_count_bytes = cnt;
        bus.write_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("ready_drop", int'(bus.write_ready), 0);
        for (int i = 0; i < hold; i++) begin
            bus.sensor_select = ~bus.sensor_select;
            bus.write_data = bus.write_data ^ 8'hFF;
            bus.write_count_bytes = bus.write_count_bytes + 3'd1;
            @(negedge clk);
        end
        bus.write_start = 1'b0;
        wait_ready();
        chk("ready_back", int'(bus.write_ready), 1);
        m_busy = cyc - c0 - 1;
    endtask

    task automatic check_txn(input string tag, input bit sel, input logic [7:0] data, input logic [2:0] cnt,
                             input logic [63:0] mb, input int exp_busy, input int exp_edges);
        int n = (cnt == 3'd0) ? 1 : int'(cnt);
        logic [7:0] mbyte = '0;
        int ones = 0;
        chk({tag, ".busy"}, m_busy, exp_busy);
        chk({tag, ".cs_sel"}, sel ? a_low - a0 : g_low - g0, CLK_DIV * (16 * n + 1));
        chk({tag, ".cs_other"}, sel ? g_low - g0 : a_low - a0, 0);
        chk({tag, ".edges"}, mosi_q.size() - e0, exp_edges);
        for (int i = 0; i < 8; i++) if (e0 + i < mosi_q.size()) mbyte = {mbyte[6:0], mosi_q[e0 + i]};
        chk({tag, ".mosi_addr"}, int'(mbyte), int'(data));
        for (int i = e0 + 8; i < mosi_q.size(); i++) ones += int'(mosi_q[i]);
        chk({tag, ".mosi_tail"}, ones, 0);
        chk({tag, ".nreads"}, rv_q.size() - r0, n - 1);
        for (int k = 1; k < n; k++)
            if (r0 + k - 1 < rv_q.size())
                chk($sformatf("%s.read%0d", tag, k), rv_q[r0 + k - 1], int'({3'(k), mb[63 - 8 * k -: 8]}));
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{sel: 1'b0, data: 8'h02, cnt: 3'd3, mb: 64'h00A53C0000000000, exp_busy: 200, exp_edges: 24};
        vecs[1] = '{sel: 1'b1, data: 8'h16, cnt: 3'd4, mb: 64'hFF01807E00000000, exp_busy: 264, exp_edges: 32};
        vecs[2] = '{sel: 1'b0, data: 8'h12, cnt: 3'd0, mb: 64'hFFFFFFFFFFFFFFFF, exp_busy: 72, exp_edges: 8};
        bus.sensor_select = 1'b0;
        bus.write_start = 1'b0;
        bus.write_data = 8'h00;
        bus.write_count_bytes = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.sclk", int'(bus.sclk), 0);
        chk("rst.mosi", int'(bus.mosi), 0);
        chk("rst.cs_gyro_n", int'(bus.cs_gyro_n), 1);
        chk("rst.cs_accl_n", int'(bus.cs_accl_n), 1);
        chk("rst.read_data", int'(bus.read_data), 0);
        chk("rst.read_valid", int'(bus.read_valid), 0);
        chk("rst.read_index", int'(bus.read_index), 0);
        chk("rst.write_ready", int'(bus.write_ready), 0);
        reset = 1'b0;
        #1 chk("rel.ready_low", int'(bus.write_ready), 0);
        @(negedge clk);
        chk("rel.ready_high", int'(bus.write_ready), 1);

        for (int i = 0; i < 3; i++) begin
            do_txn(vecs[i].sel, vecs[i].data, vecs[i].cnt, vecs[i].mb, 0);
            check_txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].cnt, vecs[i].mb,
                      vecs[i].exp_busy, vecs[i].exp_edges);
        end

        do_txn(1'b0, 8'h05, 3'd2, 64'h00C3000000000000, 50);
        check_txn("hold", 1'b0, 8'h05, 3'd2, 64'h00C3000000000000, 136, 16);

        wait_ready();
        r0 = rv_q.size(); e0 = mosi_q.size();
        miso_flat = 64'h005A5A0000000000;
        bus.sensor_select = 1'b1;
        bus.write_data = 8'h2F;
        bus.write_count_bytes = 3'd3;
        bus.write_start = 1'b1;
        @(negedge clk);
        bus.write_start = 1'b0;
        for (int n = 0; n < 3000 && mosi_q.size() - e0 < 12; n++) @(negedge clk);
        chk("abort.reached", int'(mosi_q.size() - e0 >= 12), 1);
        chk("abort.cs_active", int'(bus.cs_accl_n), 0);
        reset = 1'b1;
        #1;
        chk("abort.cs_gyro_n", int'(bus.cs_gyro_n), 1);
        chk("abort.cs_accl_n", int'(bus.cs_accl_n), 1);
        chk("abort.sclk", int'(bus.sclk), 0);
        chk("abort.mosi", int'(bus.mosi), 0);
        chk("abort.ready", int'(bus.write_ready), 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort.no_read", rv_q.size() - r0, 0);
        chk("abort.read_index", int'(bus.read_index), 0);
        reset = 1'b0;
        #1 chk("abort.ready_low", int'(bus.write_ready), 0);
        @(negedge clk);
        chk("abort.ready_high", int'(bus.write_ready), 1);
        do_txn(1'b1, 8'h2F, 3'd3, 64'h0011220000000000, 0);
        check_txn("after_abort", 1'b1, 8'h2F, 3'd3, 64'h0011220000000000, 200, 24);

        for (int i = 0; i < 5; i++) begin
            bit s = (i >= 2);
            logic [7:0] d = 8'(8'h43 + 2 * i);
            logic [63:0] mb = {$urandom, $urandom};
            do_txn(s, d, 3'd3, mb, 0);
            check_txn($sformatf("loop%0d", i), s, d, 3'd3, mb, CLK_DIV * 50, 24);
            if (i > 0) chk($sformatf("loop%0d.gap", i), last_gap, CLK_DIV + 1);
        end

        for (int i = 0; i < 8; i++) begin
            bit s = 1'($urandom_range(0, 1));
            logic [7:0] d = 8'($urandom);
            logic [2:0] c = 3'($urandom_range(0, 7));
            logic [63:0] mb = {$urandom, $urandom};
            int n = (c == 3'd0) ? 1 : int'(c);
            do_txn(s, d, c, mb, 0);
            check_txn($sformatf("rand%0d", i), s, d, c, mb, CLK_DIV * (16 * n + 2), 8 * n);
        end

        chk("both_cs_low", both_low, 0);
        chk("read_valid_width", rv_wide, 0);
        chk("sclk_phase", phase_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
